systolic_array_ctrl: RTL
========================

# systolic_array_ctrl

Scheduler and feeder for the 1×8 FP16 systolic array. Holds one stationary FP16 weight per processing element and streams a job of `cfg_len` A samples into PE0. It tracks bubbles through the pipeline, de-skews the staggered PE products into one aligned result row per sample, and signals job completion. It sits between the host/stream side and the array instance; the array has no enable, so all flow control lives here.

## Interface
- `NUM_PE`, 8, number of PEs in the chain.
- `DATA_WIDTH`, 16, FP16 operand/product width.
- `LEN_WIDTH`, 8, width of job length.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `w_we`  in  1  weight write strobe; honoured only in IDLE.
- `w_addr`  in  $clog2(NUM_PE)  PE index of the weight.
- `w_data`  in  DATA_WIDTH  FP16 weight.
- `start`  in  1  job start; sampled only in IDLE.
- `cfg_len`  in  LEN_WIDTH  number of A samples in the job; latched on start.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle completion pulse.
- `a_valid`  in  1  A stream valid.
- `a_data`  in  DATA_WIDTH  A sample.
- `a_ready`  out  1  A stream ready.
- `arr_a`  out  DATA_WIDTH  to PE0 Current_A.
- `arr_b`  out  NUM_PE*DATA_WIDTH  to each PE's Current_B; slice k drives PE k.
- `arr_out`  in  NUM_PE*DATA_WIDTH  PE_out of each PE; slice k comes from PE k.
- `res_valid`  out  1  aligned result row valid; no backpressure.
- `res_data`  out  NUM_PE*DATA_WIDTH  slice k = a_i × w[k].

## Operation
- States:
  - IDLE → RUN on `start` with `cfg_len` ≠ 0.
  - IDLE → DONE on `start` with `cfg_len` = 0.
  - RUN → DRAIN on the edge accepting the last sample.
  - DRAIN → DONE when the drain counter reaches LAT−1.
  - DONE → IDLE after one cycle.
- Weights:
  - Register file `w[0..NUM_PE-1]`, driven continuously on `arr_b`.
  - `w_we` is ignored outside IDLE, so weights are stable for the whole job.
  - When `start` and `w_we` occur in the same IDLE cycle, the write takes effect and the job uses the new value.
- `a_ready` = (state == RUN).
- An accept is `a_valid && a_ready`. On an accept edge:
  - `arr_a` ← `a_data`.
  - The remaining count decrements.
  - Valid bit 1 enters the tag shift register.
- On a RUN cycle with no accept: `arr_a` ← 0 and valid bit 0 enters the tag register (bubble).
- Tag shift register: depth LAT, where LAT = NUM_PE+3. Its tail drives `res_valid`.
- De-skew: PE k's product is delayed by NUM_PE−1−k registers. All slices are then registered into `res_data`.
- `res_data` updates every cycle; it is meaningful only when `res_valid` = 1.
- Products are passed through unmodified; the controller performs no FP arithmetic.
- `busy` = state ∈ {RUN, DRAIN, DONE}. `done` = (state == DONE).
- Reset values:
  - state IDLE; all weights 0.
  - `arr_a`, de-skew registers, tag register, `res_data`: 0.
  - `res_valid`, `busy`, `done`, `a_ready`: 0.
- Reset mid-job: immediate return to IDLE; in-flight results are discarded (tag register cleared).

## Timing
- A sample accepted on the edge ending cycle c:
  - On `arr_a` during c+1.
  - PE k product on `arr_out` during c+3+k.
  - Result row with `res_valid` = 1 during cycle c+LAT, where LAT = 11 for NUM_PE = 8.
- Bubbles keep their spacing: result rows appear in the same cycle pattern as accepts, delayed by LAT.
- `done` pulses in the cycle after the last `res_valid`. `busy` drops in the same edge that ends `done`.
- `start` while not IDLE is ignored.
- `cfg_len` = 0: `done` during the cycle after `start`; no `res_valid`.

## Configuration
- Macro `SA_CTRL_ABORT_EN`.
- When defined:
  - Adds input `abort` (1 bit).
  - `abort` in RUN or DRAIN → DONE next cycle.
  - On abort: tag register cleared and `res_valid` forced 0 from the next cycle. `done` still pulses once.
  - `abort` in IDLE or DONE is ignored.
- When not defined: no `abort` port; jobs always run to completion.

## Structure
- Package `sa_pkg`:
  - `NUM_PE`, `DATA_WIDTH` defaults.
  - `LAT` = NUM_PE+3.
  - State enum `sa_state_t` {IDLE, RUN, DRAIN, DONE}.
  - fp16 typedef.
- Sub-module `sa_deskew_line`: parameterised DEPTH, DATA_WIDTH delay line. Instantiated once per PE slice; DEPTH = 0 passes through.

## Test plan
- Set w = {0x3C00, 0x4000, 0x3800, 0…}, `cfg_len` = 1, `a_data` 0x4000 → one `res_valid` 11 cycles after accept; slices 0x4000, 0x4400, 0x3C00, 0x0000…; `done` the next cycle.
- `cfg_len` = 4, back-to-back accepts → 4 consecutive `res_valid` rows in order; `busy` high from the cycle after `start` through `done`.
- `cfg_len` = 3, `a_valid` low for 2 cycles between samples 1 and 2 → a 2-cycle gap in `res_valid`; exactly 3 rows.
- `w_we` during RUN with w_data 0xFFFF → ignored; results use the original weights. `start` during DRAIN → ignored.
- `cfg_len` = 0 → `done` one cycle after `start`; `res_valid` never asserted.
- `reset` low mid-DRAIN → all outputs 0 immediately; no `res_valid` after release. With `SA_CTRL_ABORT_EN`: `abort` in RUN → `done` the next cycle, no further `res_valid`.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and default sizing for the 1x8 FP16 systolic array controller.
package sa_pkg;

  localparam int unsigned SA_NUM_PE     = 8;
  localparam int unsigned SA_DATA_WIDTH = 16;
  localparam int unsigned SA_LEN_WIDTH  = 8;
  localparam int unsigned SA_LAT        = SA_NUM_PE + 3;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sa_state_t;

endpackage

// File: rtl/sa_deskew_line.sv
// Fixed-depth delay line used to re-align one PE's product slice; DEPTH = 0 is a wire.
module sa_deskew_line #(
  parameter int unsigned DEPTH      = 0,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, reset};
    assign dout      = din;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
      end
    end

    assign dout = pipe[DEPTH-1];
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Scheduler/feeder for the 1xN FP16 systolic array: weight file, A-stream feed,
// bubble tracking and product de-skew. Optional abort input under SA_CTRL_ABORT_EN.
module systolic_array_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned NUM_PE     = SA_NUM_PE,
  parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = SA_LEN_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef SA_CTRL_ABORT_EN
  input  logic                         abort,
`endif
  input  logic                         w_we,
  input  logic [$clog2(NUM_PE)-1:0]    w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         cfg_len,
  output logic                         busy,
  output logic                         done,
  input  logic                         a_valid,
  input  logic [DATA_WIDTH-1:0]        a_data,
  output logic                         a_ready,
  output logic [DATA_WIDTH-1:0]        arr_a,
  output logic [NUM_PE*DATA_WIDTH-1:0] arr_b,
  input  logic [NUM_PE*DATA_WIDTH-1:0] arr_out,
  output logic                         res_valid,
  output logic [NUM_PE*DATA_WIDTH-1:0] res_data
);

  localparam int unsigned LAT       = NUM_PE + 3;
  localparam int unsigned CNT_WIDTH = $clog2(LAT);

  sa_state_t state, state_next;

  logic [NUM_PE-1:0][DATA_WIDTH-1:0] w_q;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0] deskewed;
  logic [LEN_WIDTH-1:0]              remaining;
  logic [CNT_WIDTH-1:0]              drain_cnt;
  logic [LAT-1:0]                    tag;
  logic                              accept;
  logic                              abort_hit;

  assign accept = a_valid && a_ready;

`ifdef SA_CTRL_ABORT_EN
  assign abort_hit = abort && ((state == RUN) || (state == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state logic; abort overrides the normal flow.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (cfg_len == '0) ? DONE : RUN;
      RUN:     if (accept && (remaining == LEN_WIDTH'(1))) state_next = DRAIN;
      DRAIN:   if (drain_cnt == CNT_WIDTH'(LAT - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = DONE;
  end

  // State register with status flags decoded from the next state so they stay registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_ready <= 1'b0;
    end else begin
      state   <= state_next;
      busy    <= (state_next != IDLE);
      done    <= (state_next == DONE);
      a_ready <= (state_next == RUN);
    end
  end

  // Job bookkeeping: samples left to accept and cycles spent draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == IDLE) && start) remaining <= cfg_len;
      else if (accept)              remaining <= remaining - LEN_WIDTH'(1);
      drain_cnt <= (state == DRAIN) ? drain_cnt + CNT_WIDTH'(1) : '0;
    end
  end

  // Weights only change in IDLE, so a job always sees a stable set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q <= '0;
    end else if ((state == IDLE) && w_we) begin
      w_q[w_addr] <= w_data;
    end
  end

  assign arr_b = w_q;

  // Feed PE0 and track valid/bubble tags alongside the data through the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_a <= '0;
      tag   <= '0;
    end else begin
      arr_a <= accept ? a_data : '0;
      tag   <= abort_hit ? '0 : {tag[LAT-2:0], accept};
    end
  end

  assign res_valid = tag[LAT-1];

  for (genvar k = 0; k < int'(NUM_PE); k++) begin : g_pe
    sa_deskew_line #(
      .DEPTH      (NUM_PE - 1 - k),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_deskew (
      .clk   (clk),
      .reset (reset),
      .din   (arr_out[k*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (deskewed[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) res_data <= '0;
    else        res_data <= deskewed;
  end

endmodule
